// File: rtl/ws2812_chain_driver.sv
// ws2812_chain_driver: streams LED_NUM 24-bit GRB pixels, MSB first, onto a
// WS2812 chain with exact bit periods, followed by a RESET_CYC latch gap.
// Pixels arrive over a valid/ready interface into a one-deep holding register.
// Optional build macro: WS2812_BRIGHTNESS_EN adds a brightness[7:0] input that
// scales each channel as (c*(brightness+1))>>8 when a pixel enters the shifter.
module ws2812_chain_driver #(
    parameter int unsigned LED_NUM   = 8,
    parameter int unsigned T1H_CYC   = 22,
    parameter int unsigned T1L_CYC   = 10,
    parameter int unsigned T0H_CYC   = 10,
    parameter int unsigned T0L_CYC   = 22,
    parameter int unsigned RESET_CYC = 1350
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [23:0] pix_data,
`ifdef WS2812_BRIGHTNESS_EN
    input  logic [7:0]  brightness,
`endif
    output logic        busy,
    output logic        frame_done,
    output logic        underrun,
    output logic        WS2812
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_BIT_HIGH = 3'd2,
        ST_BIT_LOW  = 3'd3,
        ST_LATCH    = 3'd4
    } state_t;

    // Terminal counts are compared against phase_r, which counts from zero.
    localparam logic [31:0] T1H_LAST   = 32'(T1H_CYC - 1);
    localparam logic [31:0] T1L_LAST   = 32'(T1L_CYC - 1);
    localparam logic [31:0] T0H_LAST   = 32'(T0H_CYC - 1);
    localparam logic [31:0] T0L_LAST   = 32'(T0L_CYC - 1);
    localparam logic [31:0] LATCH_LAST = 32'(RESET_CYC - 1);
    localparam logic [8:0]  LED_NUM_W  = 9'(LED_NUM);

    state_t      state_r, state_nx;
    logic [31:0] phase_r, phase_nx;
    logic [4:0]  bit_r, bit_nx;
    logic [8:0]  sent_r, sent_nx;
    logic [8:0]  acc_r, acc_nx;
    logic [23:0] hold_r, hold_nx;
    logic        hold_full_r, hold_full_nx;
    logic [23:0] shift_r, shift_nx;
    logic        loaded_r, loaded_nx;
    logic        underrun_r, underrun_nx;
    logic        ws_r, ws_nx;
    logic        ready_r, ready_nx;
    logic        busy_r, busy_nx;
    logic        done_r, done_nx;
    logic [23:0] load_px_s;
    logic [31:0] hi_last_s;
    logic [31:0] lo_last_s;

`ifdef WS2812_BRIGHTNESS_EN
    // Scales each 8-bit channel by (br+1)/256; br=255 leaves the pixel unchanged.
    function automatic logic [23:0] scale_px(input logic [23:0] px, input logic [7:0] br);
        logic [15:0] prod;
        logic [23:0] res;
        res = 24'h000000;
        for (int i = 0; i < 3; i++) begin
            prod = {8'd0, px[i*8 +: 8]} * ({8'd0, br} + 16'd1);
            res[i*8 +: 8] = 8'(prod >> 8);
        end
        return res;
    endfunction

    assign load_px_s = scale_px(hold_r, brightness);
`else
    assign load_px_s = hold_r;
`endif

    // The current bit (shift_r[23]) selects the length of both halves.
    assign hi_last_s = shift_r[23] ? T1H_LAST : T0H_LAST;
    assign lo_last_s = shift_r[23] ? T1L_LAST : T0L_LAST;

    // Next-state, datapath and next-output computation.
    always_comb begin
        state_nx     = state_r;
        phase_nx     = phase_r;
        bit_nx       = bit_r;
        sent_nx      = sent_r;
        acc_nx       = acc_r;
        hold_nx      = hold_r;
        hold_full_nx = hold_full_r;
        shift_nx     = shift_r;
        loaded_nx    = loaded_r;
        underrun_nx  = underrun_r;

        case (state_r)
            ST_IDLE: begin
                if (frame_start) begin
                    state_nx     = ST_LOAD;
                    phase_nx     = 32'd0;
                    bit_nx       = 5'd0;
                    sent_nx      = 9'd0;
                    acc_nx       = 9'd0;
                    hold_full_nx = 1'b0;
                    loaded_nx    = 1'b0;
                    underrun_nx  = 1'b0;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_LOAD: begin
                // First pixel: one edge moves it into the shifter, the next starts the bit.
                if (loaded_r) begin
                    state_nx  = ST_BIT_HIGH;
                    phase_nx  = 32'd0;
                    loaded_nx = 1'b0;
                end else if (hold_full_r) begin
                    shift_nx     = load_px_s;
                    hold_full_nx = 1'b0;
                    bit_nx       = 5'd0;
                    sent_nx      = sent_r + 9'd1;
                    loaded_nx    = 1'b1;
                end else begin
                    loaded_nx = 1'b0;
                end
            end
            ST_BIT_HIGH: begin
                if (phase_r == hi_last_s) begin
                    state_nx = ST_BIT_LOW;
                    phase_nx = 32'd0;
                end else begin
                    phase_nx = phase_r + 32'd1;
                end
            end
            ST_BIT_LOW: begin
                if (phase_r != lo_last_s) begin
                    phase_nx = phase_r + 32'd1;
                end else if (bit_r != 5'd23) begin
                    phase_nx = 32'd0;
                    shift_nx = {shift_r[22:0], 1'b0};
                    bit_nx   = bit_r + 5'd1;
                    state_nx = ST_BIT_HIGH;
                end else if (sent_r < LED_NUM_W) begin
                    // Pixels run back to back; a missing pixel becomes black.
                    phase_nx = 32'd0;
                    bit_nx   = 5'd0;
                    sent_nx  = sent_r + 9'd1;
                    state_nx = ST_BIT_HIGH;
                    if (hold_full_r) begin
                        shift_nx     = load_px_s;
                        hold_full_nx = 1'b0;
                    end else begin
                        shift_nx    = 24'h000000;
                        underrun_nx = 1'b1;
                    end
                end else begin
                    phase_nx = 32'd0;
                    state_nx = ST_LATCH;
                end
            end
            ST_LATCH: begin
                if (phase_r == LATCH_LAST) begin
                    state_nx = ST_IDLE;
                    phase_nx = 32'd0;
                end else begin
                    phase_nx = phase_r + 32'd1;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        // Holding register fill; ready_r guarantees it is empty here.
        if (pix_valid && ready_r) begin
            hold_nx      = pix_data;
            hold_full_nx = 1'b1;
            acc_nx       = acc_r + 9'd1;
        end else begin
            hold_nx = hold_nx;
        end

        ws_nx    = (state_nx == ST_BIT_HIGH);
        ready_nx = (state_nx != ST_IDLE) && (state_nx != ST_LATCH) &&
                   !hold_full_nx && (acc_nx < LED_NUM_W);
        done_nx  = (state_nx == ST_LATCH) && (phase_nx == LATCH_LAST);
        busy_nx  = (state_nx != ST_IDLE) && !done_nx;
    end

    // State, datapath and registered outputs; rst abandons any frame in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            phase_r     <= 32'd0;
            bit_r       <= 5'd0;
            sent_r      <= 9'd0;
            acc_r       <= 9'd0;
            hold_r      <= 24'h000000;
            hold_full_r <= 1'b0;
            shift_r     <= 24'h000000;
            loaded_r    <= 1'b0;
            underrun_r  <= 1'b0;
            ws_r        <= 1'b0;
            ready_r     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_nx;
            phase_r     <= phase_nx;
            bit_r       <= bit_nx;
            sent_r      <= sent_nx;
            acc_r       <= acc_nx;
            hold_r      <= hold_nx;
            hold_full_r <= hold_full_nx;
            shift_r     <= shift_nx;
            loaded_r    <= loaded_nx;
            underrun_r  <= underrun_nx;
            ws_r        <= ws_nx;
            ready_r     <= ready_nx;
            busy_r      <= busy_nx;
            done_r      <= done_nx;
        end
    end

    assign WS2812     = ws_r;
    assign pix_ready  = ready_r;
    assign busy       = busy_r;
    assign frame_done = done_r;
    assign underrun   = underrun_r;

endmodule

// File: tb/tb_ws2812_chain_driver.sv
// Self-checking bench for ws2812_chain_driver: a line monitor decodes WS2812
// bit timing into pixels and compares them against a scoreboard queue filled
// by the directed stimulus.
`timescale 1ns/1ps
module tb_ws2812_chain_driver;
    localparam int LEDS    = 3;
    localparam int T1H     = 22;
    localparam int T1L     = 10;
    localparam int T0H     = 10;
    localparam int T0L     = 22;
    localparam int RST_CYC = 1350;
    localparam int PIX_CYC = 24 * 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start;
    logic        pix_valid;
    logic        pix_ready;
    logic [23:0] pix_data;
    logic        busy;
    logic        frame_done;
    logic        underrun;
    logic        ws;
`ifdef WS2812_BRIGHTNESS_EN
    logic [7:0]  brightness = 8'd255;
`endif

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cnt = 0;
    int acc_cnt = 0;
    logic [23:0] exp_q[$];

    ws2812_chain_driver #(
        .LED_NUM(LEDS), .T1H_CYC(T1H), .T1L_CYC(T1L),
        .T0H_CYC(T0H), .T0L_CYC(T0L), .RESET_CYC(RST_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .frame_start(frame_start),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .pix_data(pix_data),
`ifdef WS2812_BRIGHTNESS_EN
        .brightness(brightness),
`endif
        .busy(busy),
        .frame_done(frame_done),
        .underrun(underrun),
        .WS2812(ws)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // Presents px until accepted; returns the index of the accepting edge.
    task automatic send_px(input logic [23:0] px, output int acc_at);
        int n;
        n = 0;
        pix_data  = px;
        pix_valid = 1'b1;
        exp_q.push_back(px);
        while (n < 5000) begin
            @(negedge clk);
            if (pix_ready) break;
            n++;
        end
        if (n >= 5000) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        acc_at = cyc;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (n < 20000) begin
            @(negedge clk);
            if (frame_done) break;
            n++;
        end
        chk(tag, (n < 20000) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) tick();
    endtask

    // Line monitor: measures high/low run lengths and assembles pixels.
    initial begin : mon
        logic        prev;
        logic        have;
        logic        pend;
        logic        prev_busy;
        int          hi;
        int          lo;
        int          nbits;
        logic [23:0] word;
        prev = 1'b0; have = 1'b0; pend = 1'b0; prev_busy = 1'b0;
        hi = 0; lo = 0; nbits = 0; word = 24'h0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 1'b0; have = 1'b0; prev_busy = 1'b0;
                hi = 0; lo = 0; nbits = 0; word = 24'h0;
            end else begin
                if (pix_valid && pix_ready) acc_cnt++;
                if (ws) begin
                    if (!prev) begin
                        if (have) chk("bit_low_len", lo, pend ? T1L : T0L);
                        have = 1'b0;
                        hi = 0;
                    end
                    hi++;
                end else begin
                    if (prev) begin
                        pend = (hi == T1H);
                        chk("bit_high_len", hi, pend ? T1H : T0H);
                        word = {word[22:0], pend};
                        nbits++;
                        if (nbits == 24) begin
                            if (exp_q.size() == 0) chk("unexpected_pixel", {8'd0, word}, 32'hFFFFFFFF);
                            else chk("pixel", {8'd0, word}, {8'd0, exp_q.pop_front()});
                            nbits = 0;
                        end
                        have = 1'b1;
                        lo = 0;
                    end
                    lo++;
                    if (frame_done) begin
                        done_cnt++;
                        chk("busy_on_done", busy, 1'b0);
                        chk("busy_before_done", prev_busy, 1'b1);
                        chk("latch_len", have ? lo : 0, (pend ? T1L : T0L) + RST_CYC);
                        chk("whole_pixels_at_done", nbits, 0);
                        have = 1'b0;
                    end
                end
                prev = ws;
                prev_busy = busy;
            end
        end
    end

    initial begin
        int t;
        int dc;
        rst = 1'b1; frame_start = 1'b0; pix_valid = 1'b0; pix_data = 24'h0;
        repeat (3) tick();
        chk("rst_ws", ws, 1'b0);
        chk("rst_ready", pix_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", frame_done, 1'b0);
        chk("rst_underrun", underrun, 1'b0);
        rst = 1'b0;
        tick();
        chk("idle_ready", pix_ready, 1'b0);

        // Frame 1: first-pixel latency, then the rest of the frame.
        start_frame();
        chk("busy_after_start", busy, 1'b1);
        chk("ready_in_load", pix_ready, 1'b1);
        send_px(24'hFF00AA, t);
        pix_valid = 1'b0;
        chk("ready_hold_full", pix_ready, 1'b0);
        tick();
        chk("ws_low_n1", ws, 1'b0);
        tick();
        chk("ws_high_n2", ws, 1'b1);
        send_px(24'h123456, t);
        send_px(24'h800001, t);
        pix_valid = 1'b0;
        chk("ready_after_last", pix_ready, 1'b0);
        wait_done("f1_done");
        chk("f1_underrun", underrun, 1'b0);
        tick();
        chk("done_one_cycle", frame_done, 1'b0);
        chk("f1_done_cnt", done_cnt, 1);
        chk("f1_accepts", acc_cnt, 3);

        // Frame 2: valid held across all pixels; frame_start while busy and on frame_done.
        start_frame();
        send_px(24'hA5C3F0, t);
        send_px(24'h0F1E2D, t);
        send_px(24'hFFFFFF, t);
        pix_valid = 1'b0;
        start_frame();
        chk("busy_ignore_start", busy, 1'b1);
        repeat (100) tick();
        chk("ready_stays_low", pix_ready, 1'b0);
        wait_done("f2_done");
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("start_on_done_ignored", busy, 1'b0);
        chk("f2_accepts", acc_cnt, 6);
        start_frame();
        chk("start_after_done", busy, 1'b1);

        // Frame 3: second pixel late -> black slot, sticky underrun, late pixel in slot 3.
        send_px(24'h00FF00, t);
        pix_valid = 1'b0;
        exp_q.push_back(24'h000000);
        wait_cyc(t + 2 + PIX_CYC - 10);
        chk("underrun_before", underrun, 1'b0);
        wait_cyc(t + 2 + PIX_CYC + 10);
        chk("underrun_set", underrun, 1'b1);
        send_px(24'h3C3C3C, t);
        pix_valid = 1'b0;
        wait_done("f3_done");
        chk("underrun_sticky", underrun, 1'b1);
        chk("f3_done_cnt", done_cnt, 3);
        tick();

        // Frame 4: reset during bit 10 of pixel 2.
        start_frame();
        chk("underrun_cleared", underrun, 1'b0);
        send_px(24'h55AA55, t);
        dc = t;
        send_px(24'hC0FFEE, t);
        send_px(24'h010203, t);
        pix_valid = 1'b0;
        wait_cyc(dc + 2 + PIX_CYC + 10 * 32 + 5);
        chk("ws_active_pre_rst", busy, 1'b1);
        rst = 1'b1;
        tick();
        chk("midrst_ws", ws, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_ready", pix_ready, 1'b0);
        chk("midrst_done", frame_done, 1'b0);
        rst = 1'b0;
        exp_q.delete();
        dc = done_cnt;
        repeat (3000) tick();
        chk("no_done_after_rst", done_cnt, dc);

        // Frame 5: clean frame after reset.
        start_frame();
        send_px(24'h808080, t);
        send_px(24'h7F7F7F, t);
        send_px(24'h000001, t);
        pix_valid = 1'b0;
        wait_done("f5_done");
        chk("f5_underrun", underrun, 1'b0);
        chk("total_done", done_cnt, 4);
        chk("total_accepts", acc_cnt, 14);
        chk("queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
